// File: rtl/rob_rollback_ctrl.sv
// rob_rollback_ctrl
//   Branch-misprediction recovery sequencer for the 2-way R10K pipeline.
//   On a mispredict it walks the squashed ROB entries youngest-first, two per
//   cycle. For each entry it returns tag to the free list and restores the map
//   table to tagOld. It then strobes the ROB tail back to the recovery tail.
//   rb_busy holds dispatch off while a recovery is in flight.
//
// Ports
//   clk, reset                  clock / async active-low reset
//   br_fub_pred_wrong           mispredict report
//   bs_recov_rob_tail           last surviving ROB entry (the branch)
//   rob_head, rob_tail          current ROB head / youngest occupied entry
//   rb_rd_idx[1:0]              ROB read indices (slot 0 younger)
//   rob_rd_tag/tagOld/areg      combinational ROB read data for rb_rd_idx
//   rb_free_en/tag              free-list return, per slot
//   rb_map_en/areg/tag          map-table restore, per slot (slot 1 wins)
//   rb_set_tail, rb_new_tail    one-cycle ROB tail rewrite
//   rb_busy, rb_done            recovery in progress / completion strobe
//
// Optional feature macro: RB_STATS_EN
//   Adds rb_nRecoveries / rb_nSquashed 16-bit wrapping counters.

module rob_rollback_ctrl #(
  parameter int ROB_SIZE = 32,
  parameter int PTR_W    = 5,
  parameter int PREG_W   = 6,
  parameter int AREG_W   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         br_fub_pred_wrong,
  input  logic [PTR_W-1:0]             bs_recov_rob_tail,
  input  logic [PTR_W-1:0]             rob_head,
  input  logic [PTR_W-1:0]             rob_tail,
  output logic [1:0][PTR_W-1:0]        rb_rd_idx,
  input  logic [1:0][PREG_W-1:0]       rob_rd_tag,
  input  logic [1:0][PREG_W-1:0]       rob_rd_tagOld,
  input  logic [1:0][AREG_W-1:0]       rob_rd_areg,
  output logic [1:0]                   rb_free_en,
  output logic [1:0][PREG_W-1:0]       rb_free_tag,
  output logic [1:0]                   rb_map_en,
  output logic [1:0][AREG_W-1:0]       rb_map_areg,
  output logic [1:0][PREG_W-1:0]       rb_map_tag,
  output logic                         rb_set_tail,
  output logic [PTR_W-1:0]             rb_new_tail,
  output logic                         rb_busy,
`ifdef RB_STATS_EN
  output logic [15:0]                  rb_nRecoveries,
  output logic [15:0]                  rb_nSquashed,
`endif
  output logic                         rb_done
);

  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(ROB_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WALK, FIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   cursor_q, cursor_d;
  logic [PTR_W-1:0]   target_q, target_d;
  logic [PTR_W:0]     remaining_q, remaining_d;
  logic [1:0]         n_sq;
  logic               walk;
  logic [PTR_W-1:0]   new_dist, tgt_dist;
  logic               older;

  assign walk = (state_q == WALK);

  // Entries squashed this cycle: min(2, remaining) while walking.
  always_comb begin
    n_sq = 2'd0;
    if (walk) n_sq = (remaining_q >= (PTR_W+1)'(2)) ? 2'd2 : remaining_q[1:0];
  end

  // Age relative to head decides whether a nested mispredict is older.
  assign new_dist = (bs_recov_rob_tail - rob_head) & PTR_MASK;
  assign tgt_dist = (target_q - rob_head) & PTR_MASK;
  assign older    = br_fub_pred_wrong && (new_dist < tgt_dist);

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: if (br_fub_pred_wrong) begin
        cursor_d    = rob_tail;
        target_d    = bs_recov_rob_tail;
        remaining_d = {1'b0, (rob_tail - bs_recov_rob_tail) & PTR_MASK};
        state_d     = (remaining_d == '0) ? FIN : WALK;
      end
      WALK: begin
        cursor_d    = cursor_q - PTR_W'(n_sq);
        remaining_d = remaining_q - (PTR_W+1)'(n_sq);
        state_d     = (remaining_d == '0) ? FIN : WALK;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Older nested mispredict: extend the walk down to the new branch; the
    // slots freed this cycle still count, so subtract them from the distance.
    if (state_q != IDLE && older) begin
      target_d    = bs_recov_rob_tail;
      remaining_d = {1'b0, (cursor_q - bs_recov_rob_tail) & PTR_MASK} - (PTR_W+1)'(n_sq);
      state_d     = (remaining_d == '0) ? FIN : WALK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      target_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
    end
  end

  assign rb_rd_idx[0] = walk ? cursor_q : '0;
  assign rb_rd_idx[1] = walk ? ((cursor_q - PTR_W'(1)) & PTR_MASK) : '0;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic act;
    assign act            = (i == 0) ? (n_sq != 2'd0) : (n_sq == 2'd2);
    assign rb_free_en[i]  = act;
    assign rb_free_tag[i] = act ? rob_rd_tag[i]    : '0;
    assign rb_map_en[i]   = act;
    assign rb_map_areg[i] = act ? rob_rd_areg[i]   : '0;
    assign rb_map_tag[i]  = act ? rob_rd_tagOld[i] : '0;
  end

  assign rb_busy     = (state_q != IDLE);
  assign rb_set_tail = (state_q == FIN);
  assign rb_done     = (state_q == FIN);
  assign rb_new_tail = (state_q == FIN) ? target_q : '0;

`ifdef RB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_nRecoveries <= '0;
      rb_nSquashed   <= '0;
    end else begin
      if (rb_done) rb_nRecoveries <= rb_nRecoveries + 16'd1;
      rb_nSquashed <= rb_nSquashed + 16'(rb_free_en[0]) + 16'(rb_free_en[1]);
    end
  end
`endif

endmodule

// File: tb/tb_rob_rollback_ctrl.sv
// Self-checking bench for rob_rollback_ctrl. A queue-based model lists the
// squashed ROB indices youngest-first and pops up to two per busy cycle.
module tb_rob_rollback_ctrl;
  localparam int N = 32, PW = 5, GW = 6, AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic br_fub_pred_wrong;
  logic [PW-1:0] bs_recov_rob_tail, rob_head, rob_tail;
  logic [1:0][PW-1:0] rb_rd_idx;
  logic [1:0][GW-1:0] rob_rd_tag, rob_rd_tagOld;
  logic [1:0][AW-1:0] rob_rd_areg;
  logic [1:0] rb_free_en, rb_map_en;
  logic [1:0][GW-1:0] rb_free_tag, rb_map_tag;
  logic [1:0][AW-1:0] rb_map_areg;
  logic rb_set_tail, rb_busy, rb_done;
  logic [PW-1:0] rb_new_tail;
`ifdef RB_STATS_EN
  logic [15:0] rb_nRecoveries, rb_nSquashed;
`endif

  rob_rollback_ctrl #(.ROB_SIZE(N), .PTR_W(PW), .PREG_W(GW), .AREG_W(AW)) dut (
    .clk(clk), .reset(reset),
    .br_fub_pred_wrong(br_fub_pred_wrong), .bs_recov_rob_tail(bs_recov_rob_tail),
    .rob_head(rob_head), .rob_tail(rob_tail),
    .rb_rd_idx(rb_rd_idx), .rob_rd_tag(rob_rd_tag), .rob_rd_tagOld(rob_rd_tagOld),
    .rob_rd_areg(rob_rd_areg),
    .rb_free_en(rb_free_en), .rb_free_tag(rb_free_tag),
    .rb_map_en(rb_map_en), .rb_map_areg(rb_map_areg), .rb_map_tag(rb_map_tag),
    .rb_set_tail(rb_set_tail), .rb_new_tail(rb_new_tail), .rb_busy(rb_busy),
`ifdef RB_STATS_EN
    .rb_nRecoveries(rb_nRecoveries), .rb_nSquashed(rb_nSquashed),
`endif
    .rb_done(rb_done)
  );

  always #5 clk = ~clk;

  // ROB storage model with a combinational read port.
  logic [GW-1:0] rob_tag [N];
  logic [GW-1:0] rob_told[N];
  logic [AW-1:0] rob_areg[N];
  logic [GW-1:0] tb_map  [N];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rob_rd_tag[i]    = rob_tag[rb_rd_idx[i]];
      rob_rd_tagOld[i] = rob_told[rb_rd_idx[i]];
      rob_rd_areg[i]   = rob_areg[rb_rd_idx[i]];
    end
  end

  int errors = 0, checks = 0;
  logic [PW-1:0] freed_q[$];
  int done_cyc, busy_cnt, m_recov, m_sq;
  logic [PW-1:0] seen_tail;

  task automatic fill_rob();
    for (int i = 0; i < N; i++) begin
      rob_tag[i]  = GW'($urandom);
      rob_told[i] = GW'($urandom);
      rob_areg[i] = AW'($urandom);
      tb_map[i]   = '0;
    end
  endtask

  // Drives one recovery (optionally with a second mispredict at nest_cyc) and
  // compares every cycle with the queue model. Starts and ends just after a
  // falling edge.
  task automatic run_recovery(input logic [PW-1:0] head, input logic [PW-1:0] tail,
                              input logic [PW-1:0] recov, input int nest_cyc,
                              input logic [PW-1:0] nrecov);
    logic [PW-1:0] q[$];
    logic [PW-1:0] tgt, rv, j, dh, dt, e_idx1;
    logic [1:0] e_en;
    bit active, was, pw, e_done;
    int n;
    tgt = '0; active = 0;
    freed_q.delete(); done_cyc = -1; busy_cnt = 0; seen_tail = '0;
    rob_head = head; rob_tail = tail;
    for (int cyc = 0; cyc < 40; cyc++) begin
      pw = (cyc == 0) || (nest_cyc > 0 && cyc == nest_cyc);
      rv = (cyc == 0) ? recov : nrecov;
      br_fub_pred_wrong = pw; bs_recov_rob_tail = rv;
      #1;
      n = (active && q.size() > 0) ? ((q.size() >= 2) ? 2 : q.size()) : 0;
      e_en   = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      e_done = active && (q.size() == 0);
      checks++;
      if ({rb_busy, rb_done, rb_set_tail, rb_new_tail} !== {active, e_done, e_done, (e_done ? tgt : 5'd0)}) begin
        errors++;
        $display("FAIL ctl cyc=%0d got busy/done/set/tail=%b%b%b/%0d exp %b%b%b/%0d",
                 cyc, rb_busy, rb_done, rb_set_tail, rb_new_tail, active, e_done, e_done, e_done ? tgt : 5'd0);
      end
      checks++;
      if ({rb_free_en, rb_map_en} !== {e_en, e_en}) begin
        errors++;
        $display("FAIL en cyc=%0d got free=%b map=%b exp %b", cyc, rb_free_en, rb_map_en, e_en);
      end
      if (n > 0) begin
        e_idx1 = q[0] - 5'd1;
        checks++;
        if ({rb_rd_idx[0], rb_rd_idx[1]} !== {q[0], e_idx1}) begin
          errors++;
          $display("FAIL rd_idx cyc=%0d got %0d,%0d exp %0d,%0d", cyc, rb_rd_idx[0], rb_rd_idx[1], q[0], e_idx1);
        end
        for (int i = 0; i < n; i++) begin
          checks++;
          if ({rb_free_tag[i], rb_map_areg[i], rb_map_tag[i]} !==
              {rob_tag[q[i]], rob_areg[q[i]], rob_told[q[i]]}) begin
            errors++;
            $display("FAIL slot%0d cyc=%0d got tag/areg/old=%0d/%0d/%0d exp %0d/%0d/%0d", i, cyc,
                     rb_free_tag[i], rb_map_areg[i], rb_map_tag[i], rob_tag[q[i]], rob_areg[q[i]], rob_told[q[i]]);
          end
        end
      end
      // Observations of the DUT for scenario-level checks.
      if (rb_busy) busy_cnt++;
      if (rb_done) begin
        if (done_cyc < 0) done_cyc = cyc;
        seen_tail = rb_new_tail;
      end
      for (int i = 0; i < 2; i++) if (rb_free_en[i]) freed_q.push_back(rb_rd_idx[i]);
      if (rb_map_en[0]) tb_map[rb_map_areg[0]] = rb_map_tag[0];
      if (rb_map_en[1]) tb_map[rb_map_areg[1]] = rb_map_tag[1];
      m_sq += n;
      if (e_done) m_recov++;
      // Model update.
      was = active;
      for (int i = 0; i < n; i++) void'(q.pop_front());
      if (e_done) active = 0;
      if (pw) begin
        if (!was) begin
          q.delete(); j = tail;
          while (j != rv) begin q.push_back(j); j = j - 5'd1; end
          tgt = rv; active = 1;
        end else begin
          dh = rv - head; dt = tgt - head;
          if (dh < dt) begin
            j = tgt;
            while (j != rv) begin q.push_back(j); j = j - 5'd1; end
            tgt = rv; active = 1;
          end
        end
      end
      @(negedge clk);
      if (!active) break;
    end
    br_fub_pred_wrong = 1'b0;
    if (active) begin
      checks++; errors++;
      $display("FAIL timeout recovery still active after 40 cycles exp idle");
    end
`ifdef RB_STATS_EN
    #1;
    checks++;
    if ({rb_nRecoveries, rb_nSquashed} !== {16'(m_recov), 16'(m_sq)}) begin
      errors++;
      $display("FAIL stats got rec=%0d sq=%0d exp %0d %0d", rb_nRecoveries, rb_nSquashed, m_recov, m_sq);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; br_fub_pred_wrong = 1'b0; bs_recov_rob_tail = '0;
    rob_head = '0; rob_tail = '0; m_recov = 0; m_sq = 0;
    fill_rob();
    #1;
    checks++;
    if ({rb_busy, rb_done, rb_set_tail, rb_new_tail, rb_rd_idx, rb_free_en, rb_map_en} !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b set=%b tail=%0d idx=%h en=%b/%b exp all 0",
               rb_busy, rb_done, rb_set_tail, rb_new_tail, rb_rd_idx, rb_free_en, rb_map_en);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    rob_head = 5'd0; rob_tail = 5'd20;
    br_fub_pred_wrong = 1'b1; bs_recov_rob_tail = 5'd0;
    @(negedge clk);                      // T accepted
    br_fub_pred_wrong = 1'b0;
    @(negedge clk);                      // T+1 walking
    @(negedge clk);                      // T+2
    checks++;
    if (rb_busy !== 1'b1 || rb_free_en !== 2'b11) begin
      errors++;
      $display("FAIL midwalk_pre got busy=%b en=%b exp 1 11", rb_busy, rb_free_en);
    end
    #1 reset = 1'b0;
    #1;
    m_recov = 0; m_sq = 0;
    checks++;
    if ({rb_busy, rb_done, rb_set_tail, rb_new_tail, rb_rd_idx, rb_free_en, rb_map_en} !== '0) begin
      errors++;
      $display("FAIL midwalk_reset got busy=%b done=%b en=%b idx=%h exp all 0",
               rb_busy, rb_done, rb_free_en, rb_rd_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({rb_busy, rb_done} !== 2'b00) begin
      errors++;
      $display("FAIL midwalk_release got busy=%b done=%b exp 0 0", rb_busy, rb_done);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_k5();
    run_recovery(5'd0, 5'd10, 5'd5, 0, 5'd0);
    checks++;
    if (freed_q.size() != 5 || freed_q[0] !== 5'd10 || freed_q[1] !== 5'd9 ||
        freed_q[2] !== 5'd8 || freed_q[3] !== 5'd7 || freed_q[4] !== 5'd6) begin
      errors++;
      $display("FAIL k5_order got n=%0d exp 5 frees 10..6", freed_q.size());
    end
    checks++;
    if (done_cyc != 4 || seen_tail !== 5'd5 || busy_cnt != 4) begin
      errors++;
      $display("FAIL k5_timing got done@%0d tail=%0d busy=%0d exp 4 5 4", done_cyc, seen_tail, busy_cnt);
    end
  endtask

  task automatic test_wrap();
    run_recovery(5'd28, 5'd2, 5'd30, 0, 5'd0);
    checks++;
    if (freed_q.size() != 4 || freed_q[0] !== 5'd2 || freed_q[1] !== 5'd1 ||
        freed_q[2] !== 5'd0 || freed_q[3] !== 5'd31 || seen_tail !== 5'd30) begin
      errors++;
      $display("FAIL wrap got n=%0d tail=%0d exp 4 frees 2,1,0,31 tail 30", freed_q.size(), seen_tail);
    end
  endtask

  task automatic test_k0();
    run_recovery(5'd0, 5'd7, 5'd7, 0, 5'd0);
    checks++;
    if (freed_q.size() != 0 || done_cyc != 1 || seen_tail !== 5'd7) begin
      errors++;
      $display("FAIL k0 got frees=%0d done@%0d tail=%0d exp 0 1 7", freed_q.size(), done_cyc, seen_tail);
    end
  endtask

  task automatic test_nested();
    run_recovery(5'd0, 5'd20, 5'd15, 1, 5'd12);
    checks++;
    if (freed_q.size() != 8 || freed_q[7] !== 5'd13 || seen_tail !== 5'd12) begin
      errors++;
      $display("FAIL nested got frees=%0d tail=%0d exp 8 ending at 13 tail 12", freed_q.size(), seen_tail);
    end
  endtask

  task automatic test_back_to_back();
    run_recovery(5'd0, 5'd10, 5'd5, 1, 5'd5);   // repeat of same branch is ignored
    checks++;
    if (freed_q.size() != 5 || done_cyc != 4) begin
      errors++;
      $display("FAIL b2b got frees=%0d done@%0d exp 5 4", freed_q.size(), done_cyc);
    end
  endtask

  task automatic test_same_areg();
    rob_areg[9] = 5'd3; rob_told[9] = 6'd40;
    rob_areg[8] = 5'd3; rob_told[8] = 6'd33;
    tb_map[3] = 6'd0;
    run_recovery(5'd0, 5'd9, 5'd7, 0, 5'd0);
    checks++;
    if (tb_map[3] !== 6'd33) begin
      errors++;
      $display("FAIL same_areg got map[3]=%0d exp 33", tb_map[3]);
    end
  endtask

  task automatic test_max_k();
    run_recovery(5'd0, 5'd31, 5'd0, 0, 5'd0);
    checks++;
    if (freed_q.size() != 31 || busy_cnt != 17 || done_cyc != 17) begin
      errors++;
      $display("FAIL max_k got frees=%0d busy=%0d done@%0d exp 31 17 17", freed_q.size(), busy_cnt, done_cyc);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] head, tail, recov, nrec;
    int occ, k, nc;
    for (int it = 0; it < 40; it++) begin
      fill_rob();
      head  = PW'($urandom);
      occ   = $urandom_range(0, N-1);
      tail  = head + PW'(occ);
      k     = $urandom_range(0, occ);
      recov = tail - PW'(k);
      nc    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      nrec  = head + PW'($urandom_range(0, N-1));
      run_recovery(head, tail, recov, nc, nrec);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_walk();
    test_basic_k5();
    test_wrap();
    test_k0();
    test_nested();
    test_back_to_back();
    test_same_areg();
    test_max_k();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
